// File: rtl/pipelined_lookahead_adder.sv
// Pipelined lookahead adder: WIDTH-bit a+b+cin resolved SEG_W bits per stage, SEGMENTS=WIDTH/SEG_W stages.
// Latency SEGMENTS cycles from accept to out_valid, throughput one beat per cycle.
// Backpressure: every stage holds while out_valid && !out_ready; in_ready = !out_valid || out_ready.
//
// Ports: clk, rst (sync, active-high) | in_valid/in_ready, a, b, cin (operand beat)
//        out_valid/out_ready, sum, cout (result beat) | ovf (signed overflow, optional)
// Optional feature: define ADDER_OVF_EN to add the ovf output and its pipeline bit.
module pipelined_lookahead_adder #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SEGMENTS = WIDTH / SEG_W;

  generate
    if ((WIDTH % SEG_W) != 0) begin : g_bad_width
      $error("pipelined_lookahead_adder: WIDTH must be a multiple of SEG_W");
    end
  endgenerate

  // Stage k registers hold the beat after slice k has been resolved: the
  // operands (upper slices still needed downstream), the partial sum with
  // slices 0..k filled in, and the carry out of slice k.
  logic             v_q [SEGMENTS];
  logic             c_q [SEGMENTS];
  logic [WIDTH-1:0] a_q [SEGMENTS];
  logic [WIDTH-1:0] b_q [SEGMENTS];
  logic [WIDTH-1:0] s_q [SEGMENTS];

  // Inputs presented to stage k this cycle, and that stage's next values.
  logic             v_in  [SEGMENTS];
  logic             c_in  [SEGMENTS];
  logic [WIDTH-1:0] a_in  [SEGMENTS];
  logic [WIDTH-1:0] b_in  [SEGMENTS];
  logic [WIDTH-1:0] s_in  [SEGMENTS];
  logic [WIDTH-1:0] nx_s  [SEGMENTS];
  logic             nx_c  [SEGMENTS];

  logic             adv;
  logic             carry;
  logic [SEG_W-1:0] gen;
  logic [SEG_W-1:0] prop;

  // One global advance enable: the pipeline moves as a rigid shift register,
  // so bubbles are preserved and no stage needs its own handshake.
  assign adv       = !v_q[SEGMENTS-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[SEGMENTS-1];
  assign sum       = s_q[SEGMENTS-1];
  assign cout      = c_q[SEGMENTS-1];

  always_comb begin
    gen   = '0;
    prop  = '0;
    carry = 1'b0;

    v_in[0] = in_valid;
    c_in[0] = cin;
    a_in[0] = a;
    b_in[0] = b;
    s_in[0] = '0;
    for (int k = 1; k < SEGMENTS; k++) begin
      v_in[k] = v_q[k-1];
      c_in[k] = c_q[k-1];
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
    end

    for (int k = 0; k < SEGMENTS; k++) begin
      gen   = a_in[k][k*SEG_W +: SEG_W] & b_in[k][k*SEG_W +: SEG_W];
      prop  = a_in[k][k*SEG_W +: SEG_W] ^ b_in[k][k*SEG_W +: SEG_W];
      carry = c_in[k];
      nx_s[k] = s_in[k];
      // Lookahead chain within the slice; flattened by synthesis into
      // generate/propagate terms across the SEG_W bits.
      for (int i = 0; i < SEG_W; i++) begin
        nx_s[k][k*SEG_W + i] = prop[i] ^ carry;
        carry = gen[i] | (prop[i] & carry);
      end
      nx_c[k] = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SEGMENTS; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < SEGMENTS; k++) begin
        v_q[k] <= v_in[k];
        // Bubbles only move the valid bit; payload keeps its last value.
        if (v_in[k]) begin
          c_q[k] <= nx_c[k];
          a_q[k] <= a_in[k];
          b_q[k] <= b_in[k];
          s_q[k] <= nx_s[k];
        end
      end
    end
  end

`ifdef ADDER_OVF_EN
  // Signed overflow: same-sign operands producing a result of the other sign.
  // Operand MSBs arrive with the beat at the last stage.
  logic nx_ovf;
  logic ovf_q;

  assign ovf = ovf_q;

  always_comb begin
    nx_ovf = (a_in[SEGMENTS-1][WIDTH-1] == b_in[SEGMENTS-1][WIDTH-1]) &&
             (nx_s[SEGMENTS-1][WIDTH-1] != a_in[SEGMENTS-1][WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv && v_in[SEGMENTS-1]) begin
      ovf_q <= nx_ovf;
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_lookahead_adder.sv
// Bench for pipelined_lookahead_adder: WIDTH=16 with SEG_W=4 (depth 4) and SEG_W=16 (depth 1).
// Directed vector table streamed through the 4-stage instance, plus hand-written
// latency, back-to-back, back-pressure and mid-flight reset sequences.
module tb_pipelined_lookahead_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, sum;
  logic         cin, cout;
  logic         in_valid2, in_ready2, out_valid2, out_ready2;
  logic [W-1:0] sum2;
  logic         cout2;
`ifdef ADDER_OVF_EN
  logic         ovf, ovf2;
`endif

  pipelined_lookahead_adder #(.WIDTH(W), .SEG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  pipelined_lookahead_adder #(.WIDTH(W), .SEG_W(16)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .cout(cout2)
`ifdef ADDER_OVF_EN
    , .ovf(ovf2)
`endif
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t tbl [12];
  vec_t expq [$];
  vec_t cur;
  vec_t mon_e;
  vec_t rv;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one beat and hold it until the DUT takes it (bounded).
  task automatic send(input vec_t v);
    logic acc;
    int   t;
    a = v.a; b = v.b; cin = v.cin; cur = v; in_valid = 1'b1;
    t = 0;
    acc = 1'b0;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      t++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((expq.size() != 0 || out_valid) && t < 100) begin
      tick();
      t++;
    end
    chk("drain_empty", expq.size(), 0);
  endtask

  // Scoreboard: on each falling edge, record the beat the coming rising edge
  // accepts and check the result it retires.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
        end else begin
          mon_e = expq.pop_front();
          chk("sum", sum, mon_e.s);
          chk("cout", cout, mon_e.co);
`ifdef ADDER_OVF_EN
          chk("ovf", ovf, mon_e.ov);
`endif
        end
      end
      if (in_valid && in_ready) expq.push_back(cur);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   lat;
    int   t;
    logic [W-1:0] held;
    logic [W:0]   full;

    //            a         b         cin   sum       cout  ovf
    tbl[0]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[1]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[2]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[4]  = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    tbl[5]  = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[6]  = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0};
    tbl[7]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[8]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[9]  = '{16'h1234, 16'h0FFF, 1'b1, 16'h2234, 1'b0, 1'b0};
    tbl[10] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    tbl[11] = '{16'h5A5A, 16'hA5A5, 1'b0, 16'hFFFF, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0;
    out_ready = 1'b1; out_ready2 = 1'b1;
    a = '0; b = '0; cin = 1'b0;
    cur = tbl[0];

    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid_d1", out_valid2, 0);
`ifdef ADDER_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif

    // Single beat: latency counted in rising edges including the accepting one
    send(tbl[0]);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", lat, 4);
    tick();
    chk("single_pulse", out_valid, 0);
    drain();

    // Whole table back-to-back
    for (int i = 0; i < 12; i++) send(tbl[i]);
    drain();

    // 8 random beats back-to-back: outputs must form 8 consecutive valid cycles
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          rv.a   = 16'($urandom);
          rv.b   = 16'($urandom);
          rv.cin = 1'($urandom);
          full   = {1'b0, rv.a} + {1'b0, rv.b} + {16'd0, rv.cin};
          rv.s   = full[W-1:0];
          rv.co  = full[W];
          rv.ov  = (rv.a[W-1] == rv.b[W-1]) && (rv.s[W-1] != rv.a[W-1]);
          send(rv);
        end
      end
      begin
        t = 0;
        while (!out_valid && t < 50) begin
          tick();
          t++;
        end
        for (int j = 0; j < 8; j++) begin
          chk("b2b_valid", out_valid, 1);
          tick();
        end
        chk("b2b_end", out_valid, 0);
      end
    join
    drain();

    // Back-pressure: stall the output for 5 cycles mid-stream
    fork
      begin
        for (int i = 0; i < 12; i++) send(tbl[i]);
      end
      begin
        t = 0;
        while (!out_valid && t < 50) begin
          tick();
          t++;
        end
        tick(); tick();
        out_ready = 1'b0;
        held = sum;
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
          chk("stall_valid", out_valid, 1);
          chk("stall_sum", sum, held);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with 3 beats in flight: none of them may ever emerge
    send(tbl[3]); send(tbl[6]); send(tbl[10]);
    rst = 1'b1;
    expq.delete();
    tick();
    rst = 1'b0;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("midrst_no_stale", out_valid, 0);
    end

    // Single-stage instance: latency 1, then reset while a result is stalled
    a = 16'h1234; b = 16'h4321; cin = 1'b0;
    in_valid2 = 1'b1;
    @(negedge clk);
    chk("d1_in_ready", in_ready2, 1);
    tick();
    in_valid2 = 1'b0;
    chk("d1_valid", out_valid2, 1);
    chk("d1_sum", sum2, 16'h5555);
    chk("d1_cout", cout2, 0);
    out_ready2 = 1'b0;
    a = 16'hFFFF; b = 16'h0000; cin = 1'b1;
    in_valid2 = 1'b1;
    tick();
    chk("d1_stall_ready", in_ready2, 0);
    chk("d1_stall_sum", sum2, 16'h5555);
    rst = 1'b1;
    in_valid2 = 1'b0;
    tick();
    rst = 1'b0;
    out_ready2 = 1'b1;
    chk("d1_rst_valid", out_valid2, 0);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("d1_no_stale", out_valid2, 0);
    end

    // Wrap-around on the single-stage instance
    a = 16'hFFFF; b = 16'h0000; cin = 1'b1;
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    chk("d1_wrap_sum", sum2, 16'h0000);
    chk("d1_wrap_cout", cout2, 1);

    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
